// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch port, the data port and the single-port memory
//            bus that mem_port_arbiter connects together.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W     address width of all ports
//   DATA_W     data width of all ports
// Signals
//   if_req/if_addr               fetch request and address   (pipeline -> arb)
//   if_rdata/if_done             fetched word, done pulse    (arb -> pipeline)
//   d_req/d_we/d_addr/d_wdata    data request                (pipeline -> arb)
//   d_rdata/d_done               load data, done pulse       (arb -> pipeline)
//   mem_valid/mem_we/mem_addr/mem_wdata  bus beat            (arb -> memory)
//   mem_ready/mem_rdata          beat completion, read data  (memory -> arb)
//   busy                         arbiter not idle            (arb -> pipeline)
// Modports
//   master : arbiter view (it masters the memory bus)
//   slave  : environment view (pipeline stages and memory)
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;

   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output if_rdata, if_done, d_rdata, d_done,
             mem_valid, mem_we, mem_addr, mem_wdata, busy
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  if_rdata, if_done, d_rdata, d_done,
             mem_valid, mem_we, mem_addr, mem_wdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory bus between instruction fetch
//            (read-only) and the data stage (load/store). Data has priority.
//            All outputs are registered.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option
//   ARB_FAIRNESS_EN : when defined, a saturating starvation counter lets fetch
//                     win after MAX_WAIT consecutive lost arbitrations.
//                     When undefined, strict data priority, no counter.
// Parameters
//   ADDR_W, DATA_W  : bus widths (must match the interface instance)
//   MAX_WAIT        : lost arbitrations before fetch wins (fairness build only)
// Ports
//   clk  : clock, rising edge
//   clr  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.master - requester ports and memory bus
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                clr,
   mem_port_arbiter_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUS_D  = 2'd1,
      ST_BUS_IF = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
   logic              if_done_q,   if_done_d;
   logic              d_done_q,    d_done_d;
   logic              busy_q,      busy_d;

   logic w_d_eff;
   logic w_if_eff;
   logic w_fetch_turn;
   logic w_grant_d;
   logic w_grant_if;

   // A requester drops req in its done cycle; a req still high then is stale.
   assign w_d_eff  = bus.d_req  & ~d_done_q;
   assign w_if_eff = bus.if_req & ~if_done_q;

`ifdef ARB_FAIRNESS_EN
   localparam int unsigned c_wait_w = $clog2(MAX_WAIT + 1);

   logic [c_wait_w-1:0] wait_cnt_q, wait_cnt_d;

   // Fetch pre-empts data only when both contend and fetch has lost enough.
   assign w_fetch_turn = w_d_eff & w_if_eff &
                         (wait_cnt_q == c_wait_w'(MAX_WAIT));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == ST_IDLE) begin
         if (w_grant_if) begin
            wait_cnt_d = '0;
         end else if (w_grant_d && w_if_eff &&
                      (wait_cnt_q != c_wait_w'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + c_wait_w'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign w_fetch_turn = 1'b0;
`endif

   assign w_grant_d  = w_d_eff & ~w_fetch_turn;
   assign w_grant_if = w_if_eff & ~w_grant_d;

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      busy_d      = busy_q;

      case (state_q)
         ST_IDLE: begin
            // Requester inputs are sampled only here; mem_ready is ignored.
            if (w_grant_d) begin
               state_d     = ST_BUS_D;
               mem_valid_d = 1'b1;
               busy_d      = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
            end else if (w_grant_if) begin
               state_d     = ST_BUS_IF;
               mem_valid_d = 1'b1;
               busy_d      = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
            end
         end

         ST_BUS_D: begin
            if (bus.mem_ready) begin
               // Stores leave the previous load data in place.
               if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
               d_done_d    = 1'b1;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         ST_BUS_IF: begin
            if (bus.mem_ready) begin
               if_rdata_d  = bus.mem_rdata;
               if_done_d   = 1'b1;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Table of transactions
//            plus hand-written sequences for arbitration, reset and
//            done-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem_rdata;
      int          waits;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      bit          is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   vec_t vecs[6];
   exp_t exp_q[$];

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      exp_t got;
      int   n;
      @(negedge clk);
      if (v.is_d) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      e = '{v.is_d, v.exp_we, v.addr, v.exp_wdata, v.exp_rdata};
      exp_q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!bus.mem_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("v%0d_grant_latency", idx), n, 0);
      got = exp_q.pop_front();
      chk($sformatf("v%0d_addr", idx),  bus.mem_addr,  got.addr);
      chk($sformatf("v%0d_we", idx),    bus.mem_we,    got.we);
      chk($sformatf("v%0d_wdata", idx), bus.mem_wdata, got.wdata);
      chk($sformatf("v%0d_busy", idx),  bus.busy,      1);
      // Requester inputs change while on the bus; the beat must not follow them.
      bus.if_addr = ~v.addr; bus.d_addr = ~v.addr; bus.d_wdata = ~v.wdata; bus.d_we = ~v.we;
      for (int w = 0; w < v.waits; w++) begin
         bus.mem_ready = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_hold_valid", idx), bus.mem_valid, 1);
         chk($sformatf("v%0d_hold_addr", idx),  bus.mem_addr,  got.addr);
         chk($sformatf("v%0d_hold_we", idx),    bus.mem_we,    got.we);
         chk($sformatf("v%0d_hold_wdata", idx), bus.mem_wdata, got.wdata);
         chk($sformatf("v%0d_hold_nodone", idx), {bus.if_done, bus.d_done}, 0);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = v.mem_rdata;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0BAD_F00D;
      bus.if_req    = 1'b0;
      bus.d_req     = 1'b0;
      if (got.is_d) begin
         chk($sformatf("v%0d_d_done", idx),  bus.d_done,  1);
         chk($sformatf("v%0d_if_done", idx), bus.if_done, 0);
         chk($sformatf("v%0d_d_rdata", idx), bus.d_rdata, got.rdata);
      end else begin
         chk($sformatf("v%0d_if_done", idx),  bus.if_done,  1);
         chk($sformatf("v%0d_d_done", idx),   bus.d_done,   0);
         chk($sformatf("v%0d_if_rdata", idx), bus.if_rdata, got.rdata);
      end
      chk($sformatf("v%0d_end_valid", idx), bus.mem_valid, 0);
      chk($sformatf("v%0d_end_we", idx),    bus.mem_we,    0);
      chk($sformatf("v%0d_end_busy", idx),  bus.busy,      0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", idx), {bus.if_done, bus.d_done}, 0);
      chk($sformatf("v%0d_idle_valid", idx), bus.mem_valid, 0);
   endtask

   // Both requesters raise together from a quiet IDLE; one must win.
   task automatic round(input bit exp_d, input int r);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      @(negedge clk);
      chk($sformatf("r%0d_valid", r), bus.mem_valid, 1);
      chk($sformatf("r%0d_addr", r), bus.mem_addr, exp_d ? 32'h200 : 32'h100);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h1000 + r;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.d_req = 1'b0; bus.if_req = 1'b0;
      chk($sformatf("r%0d_d_done", r),  bus.d_done,  exp_d);
      chk($sformatf("r%0d_if_done", r), bus.if_done, !exp_d);
      @(negedge clk);
      chk($sformatf("r%0d_quiet", r), bus.mem_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;

      //              is_d we   addr           wdata          mem_rdata     waits ewe  exp_wdata      exp_rdata
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 32'h0,         32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hBAD0_BAD0, 3, 1'b1, 32'h1234_5678, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0024, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1, 1'b0, 32'hA5A5_A5A5, 32'hCAFE_F00D};
      vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h1111_1111, 0, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D};
      vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         2, 1'b0, 32'h0,         32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 0, 1'b0, 32'h0,         32'hFFFF_FFFF};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid",    bus.mem_valid, 0);
      chk("rst_we",       bus.mem_we,    0);
      chk("rst_addr",     bus.mem_addr,  0);
      chk("rst_wdata",    bus.mem_wdata, 0);
      chk("rst_if_done",  bus.if_done,   0);
      chk("rst_d_done",   bus.d_done,    0);
      chk("rst_if_rdata", bus.if_rdata,  0);
      chk("rst_d_rdata",  bus.d_rdata,   0);
      chk("rst_busy",     bus.busy,      0);
      clr = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Simultaneous requests: data first, fetch on the IDLE cycle after d_done.
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      @(negedge clk);
      chk("sim_first_addr", bus.mem_addr, 32'h200);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555;
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.d_req = 1'b0;
      chk("sim_d_done",  bus.d_done,  1);
      chk("sim_d_rdata", bus.d_rdata, 32'h5555);
      @(negedge clk);
      chk("sim_fetch_valid", bus.mem_valid, 1);
      chk("sim_fetch_addr",  bus.mem_addr,  32'h100);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h6666;
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.if_req = 1'b0;
      chk("sim_if_done",  bus.if_done,  1);
      chk("sim_if_rdata", bus.if_rdata, 32'h6666);
      @(negedge clk);

      // Repeated contention: strict priority, or fetch on the 5th with fairness.
      for (int r = 0; r < 6; r++) begin
`ifdef ARB_FAIRNESS_EN
         round(r != 4, r);
`else
         round(1'b1, r);
`endif
      end

      // Reset mid-transaction
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      @(negedge clk);
      chk("mid_valid", bus.mem_valid, 1);
      clr = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid",    bus.mem_valid, 0);
      chk("mid_rst_busy",     bus.busy,      0);
      chk("mid_rst_if_done",  bus.if_done,   0);
      chk("mid_rst_if_rdata", bus.if_rdata,  0);
      clr = 1'b0;
      @(negedge clk);
      chk("mid_restart_valid", bus.mem_valid, 1);
      chk("mid_restart_addr",  bus.mem_addr,  32'h300);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h7777;
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.if_req = 1'b0;
      chk("mid_restart_done",   bus.if_done,  1);
      chk("mid_restart_rdata",  bus.if_rdata, 32'h7777);
      @(negedge clk);

      // Req held through the done cycle must not start a second transaction.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
      @(negedge clk);
      chk("hold_valid", bus.mem_valid, 1);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h8888;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("hold_d_done", bus.d_done, 1);
      @(negedge clk);
      bus.d_req = 1'b0;
      chk("hold_no_regrant", bus.mem_valid, 0);
      chk("hold_single_pulse", bus.d_done, 0);
      @(negedge clk);
      chk("hold_still_idle", bus.mem_valid, 0);

      // mem_ready while IDLE is ignored.
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h9999;
      @(negedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("idle_ready_done",   {bus.if_done, bus.d_done}, 0);
      chk("idle_ready_rdata",  bus.d_rdata, 32'h8888);
      chk("idle_ready_valid",  bus.mem_valid, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sits between the pipeline and a unified instruction/data memory.
- Registered FSM with a valid/ready handshake to memory and a request/done handshake to each requester.
- Data access has priority. A starvation counter prevents fetch lock-out.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 4, consecutive lost arbitrations after which fetch wins (only used with ARB_FAIRNESS_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- clr  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid when if_done=1
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_done=1
- d_done  out  1  one-cycle data completion pulse
- mem_valid  out  1  bus request to memory
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_ready  in  1  memory accepts/completes the current beat
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- busy  out  1  FSM not in IDLE (pipeline stall hint)

Behaviour:
- All outputs are registered.
- Reset (clr=1 at an edge):
  - state=IDLE, starvation count=0.
  - mem_valid, mem_we, if_done, d_done, busy = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- States: IDLE, BUS_D, BUS_IF.
- IDLE, effective requests: a request is effective if req=1 and that port's done is not high this cycle. Requesters drop req in the done cycle; a req still high during its done is ignored for that cycle only.
- IDLE arbitration:
  - Effective d_req → BUS_D. Latch d_addr, d_we, d_wdata onto mem_addr/mem_we/mem_wdata.
  - Else effective if_req → BUS_IF. Latch if_addr, mem_we=0, mem_wdata=0.
  - Else stay IDLE.
  - mem_valid=1 and busy=1 from the first BUS_* cycle.
- BUS_x while mem_ready=0: hold mem_valid, mem_addr, mem_we and mem_wdata stable.
- BUS_x with mem_ready=1 at an edge:
  - Capture mem_rdata into x_rdata (loads and fetches only; d_rdata unchanged on a store).
  - Pulse x_done=1 for exactly the next cycle.
  - mem_valid=0, mem_we=0, busy=0, state=IDLE.
- Latency and throughput:
  - Minimum latency, req high to done high: 2 cycles (mem_ready=1 on the first bus cycle).
  - Back-to-back transactions: one idle cycle between them, so 2 cycles per transaction minimum.
- x_rdata holds its value until the next capture.
- Requester inputs are sampled only in IDLE. Changes during BUS_* are ignored.
- Reset mid-transaction: the transaction is abandoned, no done pulse, and the bus drops mem_valid at that edge.
- mem_ready while IDLE: ignored.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A saturating counter wait_cnt (width clog2(MAX_WAIT+1)) increments at each IDLE arbitration where both requests are effective and data wins.
  - When wait_cnt==MAX_WAIT and both requests are effective, fetch wins.
  - wait_cnt clears whenever fetch is granted and on reset.
- Undefined:
  - Strict data priority; no counter logic is present.
  - Fetch can starve indefinitely under continuous d_req.

Test Plan:
- Single fetch: clr 1 cycle; if_addr=0x10, if_req=1; memory returns mem_rdata=0xDEADBEEF with mem_ready on the first bus cycle → mem_valid=1 with mem_addr=0x10, mem_we=0 at cycle 1; if_done=1 with if_rdata=0xDEADBEEF at cycle 2, busy=0.
- Store with wait states: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678; mem_ready low for 3 cycles, then high → mem_addr, mem_wdata and mem_we=1 stable for all 4 bus cycles; d_done pulses once; d_rdata unchanged; if_done=0.
- Simultaneous requests: if_req=d_req=1 in the same cycle → BUS_D first (d_addr on the bus). After d_done with d_req dropped, fetch is granted on the next IDLE cycle.
- Starvation (ARB_FAIRNESS_EN, MAX_WAIT=4):
  - Stimulus: if_req held high; d_req held high, re-raised every IDLE.
  - Required: 4 data grants, then the 5th grant goes to fetch; wait_cnt returns to 0.
  - Without the macro: all grants go to data.
- Reset mid-operation: assert clr during BUS_IF with mem_ready=0 → next cycle mem_valid=0, busy=0, if_done=0, if_rdata=0. After release with if_req=1, a fresh transaction starts from IDLE.
- Done-cycle req hold: requester keeps d_req=1 during the d_done cycle, then drops it → no second bus transaction is issued.
